bp_be_rpt_assoc: RTL
====================

// Module: bp_be_rpt_assoc
// PURPOSE
// N-way set-associative reference prediction table (RPT) with a prefetch address generator.
// - Sits beside the load pipe in bp_be_checker and is trained by committed load PC/eff-addr pairs.
// - Per entry: signed stride and a saturating confidence counter.
// - At confidence, emits up to degree_p prefetch vaddrs (eff+k*stride) on a valid/ready port.
// PARAMETERS
// bp_params_p    e_bp_default_cfg  proc params (vaddr_width_p)
// sets_p         32    sets, power of 2, >=2
// ways_p         2     associativity, power of 2, 1..8
// stride_width_p 12    signed stride width (two's complement), <= vaddr_width_p
// ctr_width_p    2     saturating confidence counter width
// conf_thresh_p  3     ctr >= this -> predict; 1..2^ctr_width_p-1
// degree_p       4     prefetches issued per prediction, >=1
// PORTS
// clk_i          in  1        clock
// reset_n_i      in  1        asynchronous, active-low reset
// init_done_o    out 1        table clear complete
// train_v_i      in  1        training request valid
// train_ready_o  out 1        =init_done_o; request accepted on v&ready
// train_pc_i     in  vaddr    load PC
// train_addr_i   in  vaddr    load effective address
// pf_v_o         out 1        prefetch address valid
// pf_ready_i     in  1        consumer accepts pf_addr_o
// pf_addr_o      out vaddr    prefetch virtual address
// pf_pc_o        out vaddr    PC of training load that triggered it
// BEHAVIOUR
// - Async reset: all state cleared immediately; init_done_o=0, pf_v_o=0, pf_addr_o=0, pf_pc_o=0.
// - FSM e_reset->e_clear->e_run.
//   - e_clear writes zero rows to idx 0..sets_p-1, one per cycle.
//   - e_run entered after sets_p clear cycles; it never leaves except on reset.
//   - Reset mid-clear or mid-issue restarts from e_reset.
// - Index/tag split: idx=pc[idx_w-1:0], tag=pc[vaddr-1:idx_w].
// - Entry fields: {v, tag, last_addr, stride, ctr}. Per-set round-robin victim pointer (log2 ways_p bits).
// - Stage 0 (accept cycle): issue sync read of the row; latch pc, addr and idx.
// - Stage 1: tag compare with v-qualified hits; hit ways are one-hot.
//   - new_stride = sext-trunc(addr - last_addr).
//   - Hit and new_stride==stride: ctr saturates up.
//   - Hit and mismatch: stride<=new_stride, ctr<=0.
//   - Both hit cases: last_addr<=addr.
//   - Miss: victim way <= {1,tag,addr,0,0}, and the victim pointer advances (mod ways_p).
//   - Row written back in stage 1.
// - Hazard: a stage-0 read of the idx being written in stage 1 returns the written row (bypass). Back-to-back trains to the same PC train correctly.
// - Predict when all hold: hit, updated ctr>=conf_thresh_p, and stride!=0.
//   - The generator loads base=addr, stride=sext(stride), cnt=degree_p, pc.
// - Generator: pf_addr_o=base+stride, pf_v_o=1.
//   - On pf_v_o&pf_ready_i: base+=stride, cnt-=1, deassert after cnt reaches 0.
//   - Addition wraps modulo 2^vaddr.
//   - pf_addr_o/pf_pc_o hold while pf_v_o&~pf_ready_i.
// - New prediction while generator busy replaces the pending burst. Effective the cycle after stage 1; an in-flight handshake in the same cycle completes first.
// - Training latency: prediction from a request accepted in cycle t is pf_v_o high in t+2.
// - Miss or non-predicting hit leaves the generator untouched.
// STRUCTURE
// - bp_be_pkg: rpt entry struct macro, parametrised by tag/addr/stride/ctr widths; plus localparam idx width helper.
// - Table memory: bsg_mem_1r1w_sync, width ways_p*entry + log2(ways_p); zero-latency bypass mux in stage 1.
// - Sub-module: bp_be_rpt_pf_gen (base/stride/cnt/pc regs, valid/ready, override load).
// TESTING
// - Reset: init_done_o rises exactly sets_p cycles after reset_n_i deasserts. pf_v_o stays 0. Any train_v_i during clear is ignored.
// - Stride learn: PC 0x100, addrs 0x1000,0x1040,0x1080,0x10C0,0x1100 (conf 3):
//   - 5th train yields pf 0x1140,0x1180,0x11C0,0x1200, pf_pc_o=0x100.
// - Negative stride: addrs 0x2000,0x1FF8,... -> pf 0x1FD8-0x8k; stride change mid-run resets ctr, and no pf until 3 more matches.
// - Conflict: ways_p+1 PCs sharing idx, each trained once in rotation -> round-robin evicts the oldest; the evicted PC re-trains from ctr=0.
// - Backpressure/override: hold pf_ready_i=0 with pf_v_o high -> addr stable. New prediction replaces burst; first new address follows.
// - Async reset asserted mid-burst: pf_v_o drops same cycle; table re-clears.

Source files
------------

// File: rtl/bp_be_rpt_assoc_pkg.sv
`default_nettype none
// ============================================================================
// Module : bp_be_rpt_assoc_pkg
// Brief  : Shared types and width helpers for the set-associative RPT.
// Rev    : 1.0  initial release
// ============================================================================
package bp_be_rpt_assoc_pkg;

   // Table controller states: hold in reset, sweep-clear rows, then train.
   typedef enum logic [1:0] {
      e_reset = 2'd0,
      e_clear = 2'd1,
      e_run   = 2'd2
   } rpt_state_e;

   // Index width for a power-of-two set count.
   function automatic int idx_width(input int sets);
      return $clog2(sets);
   endfunction

   // Victim pointer width; a direct-mapped table still keeps one bit.
   function automatic int ptr_width(input int ways);
      return (ways > 1) ? $clog2(ways) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/bp_be_rpt_assoc_if.sv
`default_nettype none
// ============================================================================
// Module : bp_be_rpt_assoc_if
// Brief  : Training request and prefetch issue bundle of the RPT.
// Rev    : 1.0  initial release
// ============================================================================
interface bp_be_rpt_assoc_if #(
   parameter int vaddr_width_p = 39
);
   logic                     init_done_o;
   logic                     train_v_i;
   logic                     train_ready_o;
   logic [vaddr_width_p-1:0] train_pc_i;
   logic [vaddr_width_p-1:0] train_addr_i;
   logic                     pf_v_o;
   logic                     pf_ready_i;
   logic [vaddr_width_p-1:0] pf_addr_o;
   logic [vaddr_width_p-1:0] pf_pc_o;

   // Load pipe / prefetch consumer side.
   modport master (
      input  init_done_o, train_ready_o, pf_v_o, pf_addr_o, pf_pc_o,
      output train_v_i, train_pc_i, train_addr_i, pf_ready_i
   );

   // RPT side.
   modport slave (
      output init_done_o, train_ready_o, pf_v_o, pf_addr_o, pf_pc_o,
      input  train_v_i, train_pc_i, train_addr_i, pf_ready_i
   );
endinterface
`default_nettype wire

// File: rtl/bp_be_rpt_pf_gen.sv
`default_nettype none
// ============================================================================
// Module : bp_be_rpt_pf_gen
// Brief  : Prefetch address generator; walks base+k*stride for a burst of
//          degree_p addresses on a valid/ready port. A load replaces any
//          pending burst.
// Rev    : 1.0  initial release
// ============================================================================
module bp_be_rpt_pf_gen #(
   parameter int vaddr_width_p = 39,
   parameter int degree_p      = 4
) (
   input  wire logic                     clk_i,
   input  wire logic                     reset_n_i,
   input  wire logic                     load_i,
   input  wire logic [vaddr_width_p-1:0] load_base_i,
   input  wire logic [vaddr_width_p-1:0] load_stride_i,
   input  wire logic [vaddr_width_p-1:0] load_pc_i,
   input  wire logic                     pf_ready_i,
   output logic                          pf_v_o,
   output logic [vaddr_width_p-1:0]      pf_addr_o,
   output logic [vaddr_width_p-1:0]      pf_pc_o
);
   localparam int CNT_W = $clog2(degree_p + 1);

   logic [vaddr_width_p-1:0] r_base;
   logic [vaddr_width_p-1:0] r_stride;
   logic [vaddr_width_p-1:0] r_pc;
   logic [CNT_W-1:0]         r_cnt;
   logic                     w_fire;

   assign w_fire    = pf_v_o & pf_ready_i;
   assign pf_v_o    = (r_cnt != '0);
   assign pf_addr_o = r_base + r_stride;
   assign pf_pc_o   = r_pc;

   // Burst registers; a new load wins over a same-cycle handshake, which
   // has already delivered the current address to the consumer.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_base   <= '0;
         r_stride <= '0;
         r_pc     <= '0;
         r_cnt    <= '0;
      end else if (load_i) begin
         r_base   <= load_base_i;
         r_stride <= load_stride_i;
         r_pc     <= load_pc_i;
         r_cnt    <= CNT_W'(degree_p);
      end else if (w_fire) begin
         r_base   <= r_base + r_stride;
         r_cnt    <= r_cnt - 1'b1;
      end
   end
endmodule
`default_nettype wire

// File: rtl/bp_be_rpt_assoc.sv
`default_nettype none
// ============================================================================
// Module : bp_be_rpt_assoc
// Brief  : N-way set-associative reference prediction table. Learns a signed
//          stride per load PC and launches a prefetch burst at confidence.
// Rev    : 1.0  initial release
// ============================================================================
module bp_be_rpt_assoc
   import bp_be_rpt_assoc_pkg::*;
#(
   parameter int vaddr_width_p  = 39,
   parameter int sets_p         = 32,
   parameter int ways_p         = 2,
   parameter int stride_width_p = 12,
   parameter int ctr_width_p    = 2,
   parameter int conf_thresh_p  = 3,
   parameter int degree_p       = 4
) (
   input  wire logic          clk_i,
   input  wire logic          reset_n_i,
   bp_be_rpt_assoc_if.slave   bus
);
   localparam int IDX_W = idx_width(sets_p);
   localparam int TAG_W = vaddr_width_p - IDX_W;
   localparam int PTR_W = ptr_width(ways_p);

   typedef struct packed {
      logic                      v;
      logic [TAG_W-1:0]          tag;
      logic [vaddr_width_p-1:0]  last_addr;
      logic [stride_width_p-1:0] stride;
      logic [ctr_width_p-1:0]    ctr;
   } entry_t;

   typedef struct packed {
      entry_t [ways_p-1:0] way;
      logic   [PTR_W-1:0]  rr;
   } row_t;

   rpt_state_e r_state, w_state_n;
   logic [IDX_W-1:0] r_clr_idx, w_clr_idx_n;

   row_t r_mem [sets_p];
   row_t r_rd_row;
   logic                     r_s1_v;
   logic [vaddr_width_p-1:0] r_s1_pc;
   logic [vaddr_width_p-1:0] r_s1_addr;

   logic                      w_run, w_accept;
   logic [IDX_W-1:0]          w_idx0, w_s1_idx, w_wr_idx;
   logic [TAG_W-1:0]          w_s1_tag;
   logic                      w_wr_en;
   row_t                      w_wr_row, w_upd_row;
   logic                      w_hit, w_predict;
   logic [stride_width_p-1:0] w_new_stride, w_hit_stride;
   logic [ctr_width_p-1:0]    w_hit_ctr;

   assign w_run             = (r_state == e_run);
   assign bus.init_done_o   = w_run;
   assign bus.train_ready_o = w_run;
   assign w_accept          = bus.train_v_i & w_run;
   assign w_idx0            = bus.train_pc_i[IDX_W-1:0];
   assign w_s1_idx          = r_s1_pc[IDX_W-1:0];
   assign w_s1_tag          = r_s1_pc[vaddr_width_p-1:IDX_W];

   // Controller state and clear-sweep index.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_state   <= e_reset;
         r_clr_idx <= '0;
      end else begin
         r_state   <= w_state_n;
         r_clr_idx <= w_clr_idx_n;
      end
   end

   // Reset clears row 0 on its way out, the clear sweep covers the rest.
   always_comb begin
      w_state_n   = r_state;
      w_clr_idx_n = r_clr_idx;
      case (r_state)
         e_reset: begin
            w_state_n   = e_clear;
            w_clr_idx_n = r_clr_idx + 1'b1;
         end
         e_clear: begin
            w_clr_idx_n = r_clr_idx + 1'b1;
            if (r_clr_idx == IDX_W'(sets_p - 1)) w_state_n = e_run;
         end
         default: w_state_n = e_run;
      endcase
   end

   // Stage 0: latch the request and read its row, forwarding a same-set
   // stage-1 write so back-to-back trains see the updated entry.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_s1_v    <= 1'b0;
         r_s1_pc   <= '0;
         r_s1_addr <= '0;
         r_rd_row  <= '0;
      end else begin
         r_s1_v <= w_accept;
         if (w_accept) begin
            r_s1_pc   <= bus.train_pc_i;
            r_s1_addr <= bus.train_addr_i;
            r_rd_row  <= (w_wr_en && (w_wr_idx == w_idx0)) ? w_wr_row : r_mem[w_idx0];
         end
      end
   end

   // Stage 1: tag match, stride/confidence update or round-robin allocation.
   always_comb begin
      w_upd_row    = r_rd_row;
      w_hit        = 1'b0;
      w_new_stride = '0;
      w_hit_stride = '0;
      w_hit_ctr    = '0;
      for (int i = 0; i < ways_p; i++) begin
         if (r_rd_row.way[i].v && (r_rd_row.way[i].tag == w_s1_tag)) begin
            w_hit        = 1'b1;
            w_new_stride = stride_width_p'(r_s1_addr - r_rd_row.way[i].last_addr);
            w_upd_row.way[i].last_addr = r_s1_addr;
            if (w_new_stride == r_rd_row.way[i].stride) begin
               if (r_rd_row.way[i].ctr != '1)
                  w_upd_row.way[i].ctr = r_rd_row.way[i].ctr + 1'b1;
            end else begin
               w_upd_row.way[i].stride = w_new_stride;
               w_upd_row.way[i].ctr    = '0;
            end
            w_hit_stride = w_upd_row.way[i].stride;
            w_hit_ctr    = w_upd_row.way[i].ctr;
         end
      end
      if (!w_hit) begin
         w_upd_row.way[r_rd_row.rr] = '{v: 1'b1, tag: w_s1_tag, last_addr: r_s1_addr,
                                        stride: '0, ctr: '0};
         w_upd_row.rr = (r_rd_row.rr == PTR_W'(ways_p - 1)) ? '0 : r_rd_row.rr + 1'b1;
      end
   end

   assign w_predict = r_s1_v & w_hit & (w_hit_stride != '0) &
                      (w_hit_ctr >= ctr_width_p'(conf_thresh_p));
   assign w_wr_en   = ~w_run | r_s1_v;
   assign w_wr_idx  = w_run ? w_s1_idx : r_clr_idx;
   assign w_wr_row  = w_run ? w_upd_row : '0;

   // Table storage; contents are made valid by the clear sweep, not by reset.
   always_ff @(posedge clk_i) begin
      if (w_wr_en) r_mem[w_wr_idx] <= w_wr_row;
   end

   bp_be_rpt_pf_gen #(
      .vaddr_width_p (vaddr_width_p),
      .degree_p      (degree_p)
   ) u_pf_gen (
      .clk_i         (clk_i),
      .reset_n_i     (reset_n_i),
      .load_i        (w_predict),
      .load_base_i   (r_s1_addr),
      .load_stride_i (vaddr_width_p'($signed(w_hit_stride))),
      .load_pc_i     (r_s1_pc),
      .pf_ready_i    (bus.pf_ready_i),
      .pf_v_o        (bus.pf_v_o),
      .pf_addr_o     (bus.pf_addr_o),
      .pf_pc_o       (bus.pf_pc_o)
   );
endmodule
`default_nettype wire
